// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipeline hazard controller:
//   - write-back select encodings (WB_MEM marks a load in Execute)
//   - fwd_sel_e : operand forwarding source, values match the ForwardAE/BE encoding
//   - hz_state_e: memory-wait monitor states
package hazard_pkg;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    S_RUN     = 1'b0,
    S_MEMWAIT = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_unit.sv
// fwd_unit
// Purely combinational operand-forwarding selector for one Execute operand.
// Ports:
//   rs_addr_i  : source register address of the operand in Execute
//   rd_addr_m_i, rd_wren_m_i : destination / write enable in Memory
//   rd_addr_w_i, rd_wren_w_i : destination / write enable in Writeback
//   fwd_sel_o  : FWD_M, FWD_W or FWD_RF (Memory wins over Writeback)
module fwd_unit
  import hazard_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rd_addr_m_i,
  input  logic       rd_wren_m_i,
  input  logic [4:0] rd_addr_w_i,
  input  logic       rd_wren_w_i,
  output fwd_sel_e   fwd_sel_o
);

  logic hit_m;
  logic hit_w;

  // x0 is never forwarded: writes to it are discarded by the register file.
  assign hit_m = rd_wren_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs_addr_i);
  assign hit_w = rd_wren_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs_addr_i);

  always_comb begin
    fwd_sel_o = FWD_RF;
    if (hit_m) begin
      fwd_sel_o = FWD_M;
    end else if (hit_w) begin
      fwd_sel_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for the 5-stage RV32I core.
// Ports:
//   i_clk, i_rst (async, active-low)
//   rs1/rs2_addr_D, rs1/rs2/rd_addr_E, wb_sel_E, rd_wren_E,
//   rd_addr_M/rd_wren_M, rd_addr_W/rd_wren_W : pipeline register info
//   pc_sel_E   : taken branch/jump in Execute
//   i_lsu_busy : data memory access not complete
//   i_cnt_clr  : synchronous clear of the performance counters
//   StallF/D/E/M, FlushD/E : pipeline register hold / bubble controls
//   ForwardAE/BE : operand source (00 RF, 10 Memory, 01 Writeback)
//   o_timeout  : sticky LSU wait-timeout flag
//   o_stall_cnt, o_flush_cnt : saturating event counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WAIT_MAX = 64,
  parameter int CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       rs1_addr_D,
  input  logic [4:0]       rs2_addr_D,
  input  logic [4:0]       rs1_addr_E,
  input  logic [4:0]       rs2_addr_E,
  input  logic [4:0]       rd_addr_E,
  input  logic [1:0]       wb_sel_E,
  input  logic             rd_wren_E,
  input  logic [4:0]       rd_addr_M,
  input  logic             rd_wren_M,
  input  logic [4:0]       rd_addr_W,
  input  logic             rd_wren_W,
  input  logic             pc_sel_E,
  input  logic             i_lsu_busy,
  input  logic             i_cnt_clr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int                WAIT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX_C = WAIT_W'(WAIT_MAX);

  // ---------------------------------------------------------------------------
  // Forwarding
  // ---------------------------------------------------------------------------
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  fwd_unit u_fwd_a (
    .rs_addr_i   (rs1_addr_E),
    .rd_addr_m_i (rd_addr_M),
    .rd_wren_m_i (rd_wren_M),
    .rd_addr_w_i (rd_addr_W),
    .rd_wren_w_i (rd_wren_W),
    .fwd_sel_o   (fwd_a)
  );

  fwd_unit u_fwd_b (
    .rs_addr_i   (rs2_addr_E),
    .rd_addr_m_i (rd_addr_M),
    .rd_wren_m_i (rd_wren_M),
    .rd_addr_w_i (rd_addr_W),
    .rd_wren_w_i (rd_wren_W),
    .fwd_sel_o   (fwd_b)
  );

  // Controls are held inactive while reset is asserted.
  assign ForwardAE = i_rst ? fwd_a : FWD_RF;
  assign ForwardBE = i_rst ? fwd_b : FWD_RF;

  // ---------------------------------------------------------------------------
  // Stall / flush
  // ---------------------------------------------------------------------------
  logic lu;
  logic mw;

  assign lu = (wb_sel_E == WB_MEM) && rd_wren_E && (rd_addr_E != 5'd0) &&
              ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));
  assign mw = i_lsu_busy;

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    if (i_rst) begin
      if (mw) begin
        // Freeze everything; no flush so a branch held in Execute survives
        // and is applied once the LSU completes.
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (pc_sel_E) begin
        // Redirect kills the dependent instruction, so load-use is moot.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-wait monitor
  // ---------------------------------------------------------------------------
  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= S_RUN;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (i_lsu_busy) begin
          state_d    = S_MEMWAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      S_MEMWAIT: begin
        if (i_lsu_busy) begin
          if (wait_cnt_q < WAIT_MAX_C) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = S_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = S_RUN;
        wait_cnt_d = '0;
      end
    endcase
    // Flag raised on the edge where the count reaches WAIT_MAX while the
    // access is still outstanding; sticky until reset.
    timeout_d = timeout_q | (i_lsu_busy && (wait_cnt_d == WAIT_MAX_C));
  end

  assign o_timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (i_cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (StallF && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (FlushE && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign o_stall_cnt = stall_cnt_q;
  assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl
// Directed self-checking bench for hazard_ctrl (WAIT_MAX = 4, CNT_W = 4).
// Inputs are driven 1 time unit after a rising edge; outputs are checked in
// the same window, so combinational controls reflect the freshly driven inputs
// and registered values reflect the edge just taken.
module tb_hazard_ctrl;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 4;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic [4:0]       rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_addr_E;
  logic [1:0]       wb_sel_E;
  logic             rd_wren_E;
  logic [4:0]       rd_addr_M, rd_addr_W;
  logic             rd_wren_M, rd_wren_W;
  logic             pc_sel_E, i_lsu_busy, i_cnt_clr;
  logic             StallF, StallD, StallE, StallM, FlushD, FlushE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             o_timeout;
  logic [CNT_W-1:0] o_stall_cnt, o_flush_cnt;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE}
  logic [5:0]       ctl;
  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  hazard_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .rs1_addr_D  (rs1_addr_D),
    .rs2_addr_D  (rs2_addr_D),
    .rs1_addr_E  (rs1_addr_E),
    .rs2_addr_E  (rs2_addr_E),
    .rd_addr_E   (rd_addr_E),
    .wb_sel_E    (wb_sel_E),
    .rd_wren_E   (rd_wren_E),
    .rd_addr_M   (rd_addr_M),
    .rd_wren_M   (rd_wren_M),
    .rd_addr_W   (rd_addr_W),
    .rd_wren_W   (rd_wren_W),
    .pc_sel_E    (pc_sel_E),
    .i_lsu_busy  (i_lsu_busy),
    .i_cnt_clr   (i_cnt_clr),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .StallM      (StallM),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .o_timeout   (o_timeout),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    rs1_addr_D = 5'd0; rs2_addr_D = 5'd0;
    rs1_addr_E = 5'd0; rs2_addr_E = 5'd0; rd_addr_E = 5'd0;
    wb_sel_E   = 2'b00; rd_wren_E = 1'b0;
    rd_addr_M  = 5'd0; rd_wren_M = 1'b0;
    rd_addr_W  = 5'd0; rd_wren_W = 1'b0;
    pc_sel_E   = 1'b0; i_lsu_busy = 1'b0; i_cnt_clr = 1'b0;
  endtask

  task automatic clear_counters();
    i_cnt_clr = 1'b1;
    tick();
    i_cnt_clr = 1'b0;
  endtask

  task automatic set_load_use();
    wb_sel_E   = 2'b01;
    rd_wren_E  = 1'b1;
    rd_addr_E  = 5'd7;
    rs2_addr_D = 5'd7;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1'b0;
    // Inputs that would otherwise stall and forward.
    i_lsu_busy = 1'b1; rd_wren_M = 1'b1; rd_addr_M = 5'd3;
    rs1_addr_E = 5'd3; rs2_addr_E = 5'd3;
    tick(); tick();
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 000000", ctl);
    end
    n_checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
      n_fail++; $display("FAIL reset_fwd: got A=%b B=%b expected 00/00", ForwardAE, ForwardBE);
    end
    n_checks++;
    if (o_timeout !== 1'b0 || o_stall_cnt !== 4'd0 || o_flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_regs: got to=%b sc=%0d fc=%0d expected 0/0/0",
                         o_timeout, o_stall_cnt, o_flush_cnt);
    end
    idle_inputs();
    i_rst = 1'b1;
    tick();
    $display("reset: ctl=%b fwdA=%b to=%b", ctl, ForwardAE, o_timeout);
  endtask

  task automatic test_forwarding();
    idle_inputs();
    rd_addr_M = 5'd5; rd_addr_W = 5'd5; rs1_addr_E = 5'd5;
    rd_wren_M = 1'b1; rd_wren_W = 1'b1;
    #1;
    n_checks++;
    if (ForwardAE !== 2'b10) begin
      n_fail++; $display("FAIL fwd_m_priority: got %b expected 10", ForwardAE);
    end
    rd_addr_M = 5'd0;
    #1;
    n_checks++;
    if (ForwardAE !== 2'b01) begin
      n_fail++; $display("FAIL fwd_w_when_m_x0: got %b expected 01", ForwardAE);
    end
    rd_addr_M = 5'd9; rs2_addr_E = 5'd9;
    #1;
    n_checks++;
    if (ForwardBE !== 2'b10 || ForwardAE !== 2'b01) begin
      n_fail++; $display("FAIL fwd_b_m: got B=%b A=%b expected 10/01", ForwardBE, ForwardAE);
    end
    rd_wren_M = 1'b0; rd_addr_W = 5'd9;
    #1;
    n_checks++;
    if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
      n_fail++; $display("FAIL fwd_b_w: got B=%b A=%b expected 01/00", ForwardBE, ForwardAE);
    end
    rd_wren_W = 1'b0;
    #1;
    n_checks++;
    if (ForwardBE !== 2'b00) begin
      n_fail++; $display("FAIL fwd_none: got %b expected 00", ForwardBE);
    end
    $display("forwarding: last A=%b B=%b", ForwardAE, ForwardBE);
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use();
    idle_inputs();
    clear_counters();
    set_load_use();
    #1;
    n_checks++;
    if (ctl !== 6'b110001) begin
      n_fail++; $display("FAIL lu_active: got %b expected 110001", ctl);
    end
    tick();
    // Bubble now in Execute; the load has moved on to Memory.
    wb_sel_E = 2'b00; rd_wren_E = 1'b0; rd_addr_E = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL lu_after_bubble: got %b expected 000000", ctl);
    end
    n_checks++;
    if (o_flush_cnt !== 4'd1 || o_stall_cnt !== 4'd1) begin
      n_fail++; $display("FAIL lu_counts: got fc=%0d sc=%0d expected 1/1", o_flush_cnt, o_stall_cnt);
    end
    // A load targeting x0 never creates a hazard.
    set_load_use(); rd_addr_E = 5'd0; rs2_addr_D = 5'd0;
    #1;
    n_checks++;
    if (ctl !== 6'b000000) begin
      n_fail++; $display("FAIL lu_x0: got %b expected 000000", ctl);
    end
    $display("load_use: fc=%0d sc=%0d", o_flush_cnt, o_stall_cnt);
    idle_inputs();
    tick();
  endtask

  task automatic test_branch_over_lu();
    idle_inputs();
    set_load_use();
    pc_sel_E = 1'b1;
    #1;
    n_checks++;
    if (ctl !== 6'b000011) begin
      n_fail++; $display("FAIL branch_over_lu: got %b expected 000011", ctl);
    end
    $display("branch_over_lu: ctl=%b", ctl);
    idle_inputs();
    tick();
  endtask

  task automatic test_memwait_branch();
    idle_inputs();
    clear_counters();
    pc_sel_E   = 1'b1;
    i_lsu_busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (ctl !== 6'b111100) begin
        n_fail++; $display("FAIL memwait_cycle%0d: got %b expected 111100", c, ctl);
      end
      tick();
    end
    n_checks++;
    if (o_timeout !== 1'b0 || o_stall_cnt !== 4'd3) begin
      n_fail++; $display("FAIL memwait_regs: got to=%b sc=%0d expected 0/3", o_timeout, o_stall_cnt);
    end
    i_lsu_busy = 1'b0;
    #1;
    n_checks++;
    if (ctl !== 6'b000011) begin
      n_fail++; $display("FAIL memwait_branch_applied: got %b expected 000011", ctl);
    end
    tick();
    n_checks++;
    if (o_flush_cnt !== 4'd1) begin
      n_fail++; $display("FAIL memwait_flush_cnt: got %0d expected 1", o_flush_cnt);
    end
    $display("memwait_branch: sc=%0d fc=%0d", o_stall_cnt, o_flush_cnt);
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    idle_inputs();
    i_lsu_busy = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 3) begin
        n_checks++;
        if (o_timeout !== 1'b0) begin
          n_fail++; $display("FAIL timeout_early_edge%0d: got %b expected 0", c, o_timeout);
        end
      end else if (c >= 5) begin
        n_checks++;
        if (o_timeout !== 1'b1) begin
          n_fail++; $display("FAIL timeout_set_edge%0d: got %b expected 1", c, o_timeout);
        end
      end
    end
    i_lsu_busy = 1'b0;
    tick(); tick();
    n_checks++;
    if (o_timeout !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b expected 1", o_timeout);
    end
    i_rst = 1'b0;
    #1;
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_async_clear: got %b expected 0", o_timeout);
    end
    i_rst = 1'b1;
    tick();
    // Reset in the middle of a wait must restart the wait count.
    i_lsu_busy = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    #2;
    i_rst = 1'b1;
    tick(); tick(); tick();
    n_checks++;
    if (o_timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_midwait_reset: got %b expected 0", o_timeout);
    end
    $display("timeout: final to=%b", o_timeout);
    idle_inputs();
    tick();
  endtask

  task automatic test_counter_sat();
    idle_inputs();
    clear_counters();
    set_load_use();
    for (int c = 0; c < 20; c++) tick();
    n_checks++;
    if (o_stall_cnt !== 4'd15 || o_flush_cnt !== 4'd15) begin
      n_fail++; $display("FAIL cnt_saturate: got sc=%0d fc=%0d expected 15/15", o_stall_cnt, o_flush_cnt);
    end
    i_cnt_clr = 1'b1;
    tick();
    n_checks++;
    if (o_stall_cnt !== 4'd0 || o_flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL cnt_clear_priority: got sc=%0d fc=%0d expected 0/0", o_stall_cnt, o_flush_cnt);
    end
    i_cnt_clr = 1'b0;
    tick();
    n_checks++;
    if (o_stall_cnt !== 4'd1) begin
      n_fail++; $display("FAIL cnt_resume: got %0d expected 1", o_stall_cnt);
    end
    $display("counter_sat: sc=%0d fc=%0d", o_stall_cnt, o_flush_cnt);
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_lu();
    test_memwait_branch();
    test_timeout();
    test_counter_sat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
